// File: rtl/video_standard_ctl_pkg.sv
// Shared encodings for the video standard controller: chip selections, sequencer
// states and the helper that builds a chip code from its model and family bits.
package video_standard_ctl_pkg;

  typedef logic [1:0] chip_t;

  localparam chip_t CHIP6567R8   = 2'd0;
  localparam chip_t CHIP6569R3   = 2'd1;
  localparam chip_t CHIP6567R56A = 2'd2;
  localparam chip_t CHIP6569R1   = 2'd3;

  typedef enum logic [2:0] {
    BOOT   = 3'd0,
    RUN    = 3'd1,
    HOLD   = 3'd2,
    SWAP   = 3'd3,
    SETTLE = 3'd4
  } state_t;

  function automatic chip_t make_chip(input logic model, input logic pal);
    return {model, pal};
  endfunction

endpackage

// File: rtl/video_standard_ctl_if.sv
// Control/status bundle between the standard controller and the surrounding top:
// switch pin, model register path and the chip/reset outputs.
interface video_standard_ctl_if;
  import video_standard_ctl_pkg::*;

  logic  standard_sw;
  logic  cfg_model;
  logic  cfg_model_wr;
  chip_t chip;
  logic  cpu_reset_req;
  logic  switching;
  logic  sw_pal;

  modport master (
    output standard_sw,
    output cfg_model,
    output cfg_model_wr,
    input  chip,
    input  cpu_reset_req,
    input  switching,
    input  sw_pal
  );

  modport slave (
    input  standard_sw,
    input  cfg_model,
    input  cfg_model_wr,
    output chip,
    output cpu_reset_req,
    output switching,
    output sw_pal
  );

endinterface

// File: rtl/switch_debounce.sv
// Two-flop synchronizer plus counter debounce for the PAL/NTSC switch pin; the
// stable output is the debounced "PAL requested" level.
module switch_debounce #(
  parameter int unsigned DEBOUNCE_BITS = 20,
  parameter logic        SW_PAL_LEVEL  = 1'b0
) (
  input  logic clk_dot4x,
  input  logic rst,
  input  logic raw,
  input  logic first_sample,
  output logic stable
);

  localparam logic [DEBOUNCE_BITS-1:0] DCNT_ZERO = {DEBOUNCE_BITS{1'b0}};
  localparam logic [DEBOUNCE_BITS-1:0] DCNT_LAST = {DEBOUNCE_BITS{1'b1}};
  localparam logic [DEBOUNCE_BITS-1:0] DCNT_ONE  = {{(DEBOUNCE_BITS-1){1'b0}}, 1'b1};

  logic                     sync1_r;
  logic                     sync2_r;
  logic                     stable_r;
  logic [DEBOUNCE_BITS-1:0] dcnt_r;
  logic                     req_pal_s;

  assign req_pal_s = (sync2_r == SW_PAL_LEVEL);
  assign stable    = stable_r;

  // Synchronizer and debounce counter; the boot sample bypasses the counter once.
  always_ff @(posedge clk_dot4x) begin
    if (rst) begin
      sync1_r  <= 1'b0;
      sync2_r  <= 1'b0;
      stable_r <= 1'b0;
      dcnt_r   <= DCNT_ZERO;
    end else begin
      sync1_r <= raw;
      sync2_r <= sync1_r;
      if (first_sample) begin
        stable_r <= req_pal_s;
        dcnt_r   <= DCNT_ZERO;
      end else if (req_pal_s != stable_r) begin
        if (dcnt_r == DCNT_LAST) begin
          stable_r <= req_pal_s;
          dcnt_r   <= DCNT_ZERO;
        end else begin
          dcnt_r <= dcnt_r + DCNT_ONE;
        end
      end else begin
        dcnt_r <= DCNT_ZERO;
      end
    end
  end

endmodule

// File: rtl/video_standard_ctl.sv
// Video standard controller: owns the 2-bit chip selection and wraps every change
// of family or model in a held CPU reset so the muxed clocks can settle.
module video_standard_ctl
  import video_standard_ctl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_BITS = 20,
  parameter int unsigned HOLD_CYCLES   = 16384,
  parameter int unsigned SETTLE_CYCLES = 65536,
  parameter logic        SW_PAL_LEVEL  = 1'b0,
  parameter logic        DEFAULT_MODEL = 1'b0
) (
  input  logic                 clk_dot4x,
  input  logic                 rst,
  video_standard_ctl_if.slave  bus
);

  localparam int unsigned MAX_CYCLES = (HOLD_CYCLES > SETTLE_CYCLES) ? HOLD_CYCLES : SETTLE_CYCLES;
  localparam int unsigned TCNT_BITS  = $clog2(MAX_CYCLES) + 1;

  localparam logic [TCNT_BITS-1:0] TCNT_ZERO   = {TCNT_BITS{1'b0}};
  localparam logic [TCNT_BITS-1:0] TCNT_ONE    = TCNT_BITS'(1);
  localparam logic [TCNT_BITS-1:0] HOLD_LAST   = TCNT_BITS'(HOLD_CYCLES - 1);
  localparam logic [TCNT_BITS-1:0] SETTLE_LAST = TCNT_BITS'(SETTLE_CYCLES - 1);
  // Synchronizer output first carries the real pin level on this BOOT count.
  localparam logic [TCNT_BITS-1:0] FIRST_SAMPLE_CNT = TCNT_BITS'(2);

  state_t               state_r;
  state_t               state_s;
  logic [TCNT_BITS-1:0] tcnt_r;
  logic [TCNT_BITS-1:0] tcnt_s;
  chip_t                chip_r;
  chip_t                chip_s;
  chip_t                target_s;
  logic                 pend_model_r;
  logic                 sw_pal_s;
  logic                 first_sample_s;
  logic                 cpu_reset_req_r;
  logic                 switching_r;

  assign first_sample_s = (state_r == BOOT) && (tcnt_r == FIRST_SAMPLE_CNT);
  assign target_s       = make_chip(pend_model_r, sw_pal_s);

  switch_debounce #(
    .DEBOUNCE_BITS (DEBOUNCE_BITS),
    .SW_PAL_LEVEL  (SW_PAL_LEVEL)
  ) u_debounce (
    .clk_dot4x    (clk_dot4x),
    .rst          (rst),
    .raw          (bus.standard_sw),
    .first_sample (first_sample_s),
    .stable       (sw_pal_s)
  );

  assign bus.chip          = chip_r;
  assign bus.cpu_reset_req = cpu_reset_req_r;
  assign bus.switching     = switching_r;
  assign bus.sw_pal        = sw_pal_s;

  // Sequencer next state, shared timer and chip update.
  always_comb begin
    state_s = state_r;
    tcnt_s  = tcnt_r + TCNT_ONE;
    chip_s  = chip_r;
    case (state_r)
      BOOT: begin
        chip_s = target_s;
        if (tcnt_r == SETTLE_LAST) begin
          state_s = RUN;
          tcnt_s  = TCNT_ZERO;
        end else begin
          state_s = BOOT;
        end
      end
      RUN: begin
        tcnt_s = TCNT_ZERO;
        if (target_s != chip_r) begin
          state_s = HOLD;
        end else begin
          state_s = RUN;
        end
      end
      HOLD: begin
        if (tcnt_r == HOLD_LAST) begin
          state_s = SWAP;
          tcnt_s  = TCNT_ZERO;
        end else begin
          state_s = HOLD;
        end
      end
      SWAP: begin
        chip_s  = target_s;
        state_s = SETTLE;
        tcnt_s  = TCNT_ZERO;
      end
      SETTLE: begin
        if (tcnt_r == SETTLE_LAST) begin
          tcnt_s = TCNT_ZERO;
          // A target that moved after SWAP gets a fresh hold/swap/settle pass.
          if (target_s != chip_r) begin
            state_s = HOLD;
          end else begin
            state_s = RUN;
          end
        end else begin
          state_s = SETTLE;
        end
      end
      default: begin
        state_s = BOOT;
        tcnt_s  = TCNT_ZERO;
        chip_s  = make_chip(DEFAULT_MODEL, 1'b0);
      end
    endcase
  end

  // State, timer, chip, pending model and registered status outputs.
  always_ff @(posedge clk_dot4x) begin
    if (rst) begin
      state_r         <= BOOT;
      tcnt_r          <= TCNT_ZERO;
      chip_r          <= make_chip(DEFAULT_MODEL, 1'b0);
      pend_model_r    <= DEFAULT_MODEL;
      cpu_reset_req_r <= 1'b1;
      switching_r     <= 1'b1;
    end else begin
      state_r         <= state_s;
      tcnt_r          <= tcnt_s;
      chip_r          <= chip_s;
      cpu_reset_req_r <= (state_s != RUN);
      switching_r     <= (state_s != RUN);
      if (bus.cfg_model_wr) begin
        pend_model_r <= bus.cfg_model;
      end else begin
        pend_model_r <= pend_model_r;
      end
    end
  end

endmodule

// File: tb/tb_video_standard_ctl.sv
// Scoreboard bench for video_standard_ctl: each stimulus step queues the status
// vector {chip, cpu_reset_req, switching, sw_pal} expected on specific cycles.
module tb_video_standard_ctl;
  import video_standard_ctl_pkg::*;

  typedef struct {
    int         cyc;
    string      tag;
    logic [4:0] val;
  } exp_t;

  logic clk_dot4x = 1'b0;
  logic rst;
  int   cyc = 0;
  int unsigned checks_total  = 0;
  int unsigned checks_passed = 0;
  exp_t exp_q[$];
  exp_t cur_e;

  video_standard_ctl_if bus();

  video_standard_ctl #(
    .DEBOUNCE_BITS (3),
    .HOLD_CYCLES   (4),
    .SETTLE_CYCLES (6),
    .SW_PAL_LEVEL  (1'b0),
    .DEFAULT_MODEL (1'b0)
  ) dut (
    .clk_dot4x (clk_dot4x),
    .rst       (rst),
    .bus       (bus)
  );

  always #5 clk_dot4x = ~clk_dot4x;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp) begin
      checks_passed++;
    end else begin
      $display("FAIL %s @cyc %0d: got %05b expected %05b", tag, cyc, got[4:0], exp[4:0]);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk_dot4x);
      #1;
    end
  endtask

  task automatic span(input int a, input int b, input string tag, input logic [4:0] v);
    for (int k = a; k <= b; k++) begin
      exp_q.push_back('{k, tag, v});
    end
  endtask

  // t0 is the edge on which the target first differs from chip in RUN.
  task automatic expect_switch(input int t0, input logic [1:0] from_chip, input logic [1:0] to_chip,
                               input logic sp, input string tag);
    span(t0,      t0,      {tag, "_run"},    {from_chip, 2'b00, sp});
    span(t0 + 1,  t0 + 5,  {tag, "_hold"},   {from_chip, 2'b11, sp});
    span(t0 + 6,  t0 + 11, {tag, "_settle"}, {to_chip,   2'b11, sp});
    span(t0 + 12, t0 + 13, {tag, "_done"},   {to_chip,   2'b00, sp});
  endtask

  // Output monitor: one sample per cycle on the falling edge.
  initial begin
    forever begin
      @(negedge clk_dot4x);
      cyc = cyc + 1;
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        cur_e = exp_q.pop_front();
        check_eq(cur_e.tag,
                 {27'd0, bus.chip, bus.cpu_reset_req, bus.switching, bus.sw_pal},
                 {27'd0, cur_e.val});
      end
    end
  end

  initial begin
    int t;
    rst              = 1'b1;
    bus.standard_sw  = 1'b0;
    bus.cfg_model    = 1'b0;
    bus.cfg_model_wr = 1'b0;

    // Boot with the switch at the PAL level: chip ends at 6569R3.
    step(1);
    span(2, 2, "reset", 5'b00110);
    step(1);
    rst = 1'b0;
    span(3, 4, "boot_early",  5'b00110);
    span(5, 5, "boot_sample", 5'b00111);
    span(6, 7, "boot_chip",   5'b01111);
    span(8, 9, "boot_run",    5'b01001);
    step(9);

    // Five-cycle switch glitch in RUN: nothing moves.
    t = cyc;
    bus.standard_sw = 1'b1;
    span(t + 1, t + 16, "glitch", 5'b01001);
    step(5);
    bus.standard_sw = 1'b0;
    step(12);

    // Model write to 1, then back to 0 during SETTLE: 01 -> 11 -> 01 under one reset.
    t = cyc + 1;
    bus.cfg_model    = 1'b1;
    bus.cfg_model_wr = 1'b1;
    span(t,      t,      "model_run",    5'b01001);
    span(t + 1,  t + 5,  "model_hold",   5'b01111);
    span(t + 6,  t + 16, "model_r1",     5'b11111);
    span(t + 17, t + 22, "model_back",   5'b01111);
    span(t + 23, t + 24, "model_done",   5'b01001);
    step(1);
    bus.cfg_model_wr = 1'b0;
    step(8);
    bus.cfg_model    = 1'b0;
    bus.cfg_model_wr = 1'b1;
    step(1);
    bus.cfg_model_wr = 1'b0;
    step(16);

    // Family switch to NTSC: sw_pal falls after sync + 2^3 cycles, chip -> 00.
    t = cyc;
    bus.standard_sw = 1'b1;
    span(t + 1, t + 9, "fam_wait", 5'b01001);
    expect_switch(t + 10, 2'b01, 2'b00, 1'b0, "fam");
    step(24);

    // Target leaves and returns before SWAP: chip kept, reset exactly 11 cycles.
    t = cyc + 1;
    bus.cfg_model    = 1'b1;
    bus.cfg_model_wr = 1'b1;
    expect_switch(t, 2'b00, 2'b00, 1'b0, "same");
    step(1);
    bus.cfg_model_wr = 1'b0;
    step(2);
    bus.cfg_model    = 1'b0;
    bus.cfg_model_wr = 1'b1;
    step(1);
    bus.cfg_model_wr = 1'b0;
    step(12);

    // Family switch back to PAL: chip 00 -> 01.
    t = cyc;
    bus.standard_sw = 1'b0;
    span(t + 1, t + 9, "back_wait", 5'b00000);
    expect_switch(t + 10, 2'b00, 2'b01, 1'b1, "back");
    step(24);

    // Reset in HOLD: BOOT restarts with chip {0,0}, pending model lost, chip back to 01.
    t = cyc + 1;
    bus.cfg_model    = 1'b1;
    bus.cfg_model_wr = 1'b1;
    span(t,     t,      "mid_run",    5'b01001);
    span(t + 1, t + 2,  "mid_hold",   5'b01111);
    span(t + 3, t + 5,  "mid_reboot", 5'b00110);
    span(t + 6, t + 6,  "mid_sample", 5'b00111);
    span(t + 7, t + 8,  "mid_chip",   5'b01111);
    span(t + 9, t + 12, "mid_run2",   5'b01001);
    step(1);
    bus.cfg_model_wr = 1'b0;
    bus.cfg_model    = 1'b0;
    step(2);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(11);

    for (int i = 0; i < 50 && exp_q.size() > 0; i++) begin
      step(1);
    end
    check_eq("drain", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
